// File: rtl/rr_arb_4_1_pkg.sv
// Shared definitions for the 4:1 round-robin arbiter.
//   arb_state_e : output-stage state (IDLE = empty, HOLD = word waiting for consumer)
//   NUM_REQ     : number of requesters (fixed at 4, matches a 2-bit select)
//   SEL_W       : width of the mux select / requester index
//   sel_t       : requester index / mux select type
package arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef logic [SEL_W-1:0] sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_arb_4_1_if.sv
// Requester/consumer bundle of the 4:1 round-robin arbiter.
//   req_i        : per-requester request (held with its data until granted)
//   data0_i..3_i : requester data words, mux inputs 00..11
//   gnt_o        : one-hot combinational grant
//   sel_o        : registered mux select of the held word
//   valid_o      : output stage holds a word
//   data_o       : registered selected word
//   ready_i      : consumer accepts data_o this cycle
// master = requesters + consumer side, slave = arbiter side.
interface rr_arb_4_1_if #(
   parameter int DATA_W = 32
);
   import arb_pkg::*;

   logic [NUM_REQ-1:0] req_i;
   logic [DATA_W-1:0]  data0_i;
   logic [DATA_W-1:0]  data1_i;
   logic [DATA_W-1:0]  data2_i;
   logic [DATA_W-1:0]  data3_i;
   logic [NUM_REQ-1:0] gnt_o;
   sel_t               sel_o;
   logic               valid_o;
   logic [DATA_W-1:0]  data_o;
   logic               ready_i;

   modport master (
      output req_i, data0_i, data1_i, data2_i, data3_i, ready_i,
      input  gnt_o, sel_o, valid_o, data_o
   );

   modport slave (
      input  req_i, data0_i, data1_i, data2_i, data3_i, ready_i,
      output gnt_o, sel_o, valid_o, data_o
   );

endinterface

// File: rtl/rr_arb_4_1_pick.sv
// Rotated priority search for the round-robin arbiter (purely combinational).
//   req    : request vector
//   last   : index of the previous winner; search starts at last+1 (mod 4)
//   any    : at least one request present
//   idx    : index of the winner (0 when any==0)
//   onehot : one-hot winner vector (all zero when any==0)
module rr_pick
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  sel_t               last,
   output logic               any,
   output sel_t               idx,
   output logic [NUM_REQ-1:0] onehot
);

   sel_t cand;
   logic found;

   always_comb begin
      cand   = last;
      found  = 1'b0;
      idx    = '0;
      onehot = '0;
      // The 2-bit add wraps naturally, so candidates visit last+1 .. last+4 (== last) mod 4,
      // which puts the previous winner at the lowest priority.
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = last + sel_t'(k + 1);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      onehot[idx] = found;
      any         = found;
   end

endmodule

// File: rtl/rr_arb_4_1.sv
// 4:1 round-robin arbiter driving a 32-bit datapath mux and a single-entry
// valid/ready output stage.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset; discards any held word
//   bus   : requester/consumer bundle (slave modport), see rr_arb_4_1_if
// A new winner is taken whenever the stage is empty or is being drained in
// the same cycle, so a continuously ready consumer gets one word per cycle.
module rr_arb_4_1
   import arb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   rr_arb_4_1_if.slave bus
);

   arb_state_e         state_q;
   arb_state_e         state_d;
   sel_t               last_q;
   sel_t               sel_p1;
   logic [DATA_W-1:0]  data_p1;
   logic               vld_p1;

   logic               arb_en;
   logic               take;
   logic [NUM_REQ-1:0] gnt;
   logic [DATA_W-1:0]  mux_word;

   logic               pick_any;
   sel_t               pick_idx;
   logic [NUM_REQ-1:0] pick_onehot;

   rr_pick u_pick (
      .req    (bus.req_i),
      .last   (last_q),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   // Arbitration is allowed when the stage is empty or its word leaves this cycle;
   // reset also blocks the grant so no requester sees a grant that is then dropped.
   always_comb begin
      arb_en  = (state_q == IDLE) || bus.ready_i;
      state_d = state_q;
      take    = 1'b0;
      gnt     = '0;
      if (arb_en && !rst_i) begin
         if (pick_any) begin
            take    = 1'b1;
            gnt     = pick_onehot;
            state_d = HOLD;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_comb begin
      case (pick_idx)
         2'd0:    mux_word = bus.data0_i;
         2'd1:    mux_word = bus.data1_i;
         2'd2:    mux_word = bus.data2_i;
         2'd3:    mux_word = bus.data3_i;
         default: mux_word = bus.data0_i;
      endcase
   end

   // ---- stage p1: output register ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         last_q  <= 2'b11;
         sel_p1  <= '0;
         data_p1 <= '0;
      end else begin
         state_q <= state_d;
         if (take) begin
            last_q  <= pick_idx;
            sel_p1  <= pick_idx;
            data_p1 <= mux_word;
         end
      end
   end

   assign vld_p1      = (state_q == HOLD);
   assign bus.gnt_o   = gnt;
   assign bus.sel_o   = sel_p1;
   assign bus.valid_o = vld_p1;
   assign bus.data_o  = data_p1;

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Directed bench for rr_arb_4_1 and its rr_pick search unit.
module tb_rr_arb_4_1;
   import arb_pkg::*;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   rr_arb_4_1_if #(.DATA_W(32)) bus ();

   rr_arb_4_1 #(.DATA_W(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   logic [NUM_REQ-1:0] pr;
   sel_t               pl;
   logic               p_any;
   sel_t               p_idx;
   logic [NUM_REQ-1:0] p_onehot;

   rr_pick u_pick (
      .req    (pr),
      .last   (pl),
      .any    (p_any),
      .idx    (p_idx),
      .onehot (p_onehot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          exp_idx;
      logic        exp_any;
      logic [3:0]  exp_oh;
      errors = 0;
      checks = 0;

      rst         = 1'b1;
      bus.req_i   = '0;
      bus.ready_i = 1'b0;
      bus.data0_i = 32'd1;
      bus.data1_i = 32'd2;
      bus.data2_i = 32'd3;
      bus.data3_i = 32'd4;
      pr = '0;
      pl = '0;
      step();
      step();
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_data",  bus.data_o,  0);
      chk("rst_sel",   bus.sel_o,   0);
      chk("rst_gnt",   bus.gnt_o,   0);

      // 1: all requesting, consumer always ready -> 0,1,2,3 back to back
      rst         = 1'b0;
      bus.req_i   = 4'b1111;
      bus.ready_i = 1'b1;
      #1;
      chk("t1_gnt0", bus.gnt_o, 4'b0001);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t1_valid", bus.valid_o, 1);
         chk("t1_data",  bus.data_o,  i + 1);
         chk("t1_sel",   bus.sel_o,   i);
         if (i < 3) chk("t1_gnt", bus.gnt_o, 4'b0001 << (i + 1));
      end

      // drain to IDLE
      bus.req_i = 4'b0000;
      #1;
      chk("drain_gnt", bus.gnt_o, 0);
      step();
      chk("drain_valid", bus.valid_o, 0);

      // 2: single request from IDLE
      bus.req_i = 4'b0100;
      #1;
      chk("t2_gnt", bus.gnt_o, 4'b0100);
      step();
      chk("t2_valid", bus.valid_o, 1);
      chk("t2_data",  bus.data_o,  3);
      chk("t2_sel",   bus.sel_o,   2'b10);

      // 3: load requester 1, then backpressure with 1101 pending
      bus.req_i = 4'b0010;
      #1;
      chk("t3_gnt1", bus.gnt_o, 4'b0010);
      step();
      chk("t3_data1", bus.data_o, 2);
      bus.req_i   = 4'b1101;
      bus.ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_bp_gnt",   bus.gnt_o,   0);
         chk("t3_bp_data",  bus.data_o,  2);
         chk("t3_bp_sel",   bus.sel_o,   2'b01);
         chk("t3_bp_valid", bus.valid_o, 1);
         step();
      end
      bus.ready_i = 1'b1;
      #1;
      chk("t3_rel_gnt", bus.gnt_o, 4'b0100);
      step();
      chk("t3_rel_data", bus.data_o, 3);
      chk("t3_rel_sel",  bus.sel_o,  2'b10);

      // 4: lone requester 0 wins every cycle, then requests stop
      bus.req_i = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_gnt", bus.gnt_o, 4'b0001);
         step();
         chk("t4_data",  bus.data_o,  1);
         chk("t4_sel",   bus.sel_o,   0);
         chk("t4_valid", bus.valid_o, 1);
      end
      bus.req_i = 4'b0000;
      step();
      chk("t4_empty_valid", bus.valid_o, 0);

      // 5: asynchronous reset while holding data 4
      bus.req_i = 4'b1000;
      #1;
      chk("t5_gnt3", bus.gnt_o, 4'b1000);
      step();
      chk("t5_pre_data",  bus.data_o,  4);
      chk("t5_pre_valid", bus.valid_o, 1);
      bus.req_i   = 4'b0000;
      bus.ready_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_valid", bus.valid_o, 0);
      chk("t5_async_data",  bus.data_o,  0);
      chk("t5_async_sel",   bus.sel_o,   0);
      step();
      rst         = 1'b0;
      bus.req_i   = 4'b1001;
      bus.ready_i = 1'b1;
      #1;
      chk("t5_post_gnt", bus.gnt_o, 4'b0001);
      step();
      chk("t5_post_data", bus.data_o, 1);
      chk("t5_post_sel",  bus.sel_o,  0);
      bus.req_i = 4'b0000;

      // 6: exhaustive search-unit check against an index-walking model
      for (int r = 0; r < 16; r++) begin
         for (int l = 0; l < 4; l++) begin
            pr = 4'(r);
            pl = 2'(l);
            #1;
            exp_any = 1'b0;
            exp_idx = 0;
            for (int k = 1; k <= 4; k++) begin
               if (!exp_any && ((r >> ((l + k) % 4)) & 1) == 1) begin
                  exp_any = 1'b1;
                  exp_idx = (l + k) % 4;
               end
            end
            exp_oh = exp_any ? (4'b0001 << exp_idx) : 4'b0000;
            chk("t6_any",    p_any,    exp_any);
            chk("t6_onehot", p_onehot, exp_oh);
            if (exp_any) chk("t6_idx", p_idx, exp_idx);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arb_4_1.md
Name: rr_arb_4_1

Overview:
- Round-robin scheduler that shares the 32-bit 4:1 datapath mux among four requesters and drives its select.
- Each requester presents data with a request. The arbiter picks one, drives sel_o to the mux, and registers the chosen word into an output stage.
- It then holds that word under a valid/ready handshake toward a single consumer, for example a writeback or bus port.

Parameters:
- DATA_W, 32: width of each requester data word and of data_o.
- NUM_REQ, 4: number of requesters; fixed at 4 to match a 2-bit select. Any other value is unsupported.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req_i  in  4  per-requester request; the requester holds it and its data stable until its gnt_o bit is seen.
- data0_i, data1_i, data2_i, data3_i  in  DATA_W each  requester data words; these are mux inputs 00, 01, 10, 11.
- gnt_o  out  4  one-hot, combinational; marks the requester accepted this cycle.
- sel_o  out  2  registered mux select of the word currently held in the output stage.
- valid_o  out  1  output stage holds a word.
- data_o  out  DATA_W  registered selected word.
- ready_i  in  1  consumer accepts data_o this cycle when valid_o is high.

Behaviour:
- Reset values (asynchronous on rst_i): valid_o=0, data_o=0, sel_o=2'b00, gnt_o=0, last_q=2'b11, state=IDLE. This holds even mid-transfer; a held word is discarded.
- States:
  - IDLE: output stage empty.
  - HOLD: output stage full, waiting for ready_i.
- Arbitration opportunity (arb_en) exists in either of these cases:
  - state==IDLE, or
  - state==HOLD and ready_i==1.
- Winner selection: when arb_en and |req_i, the winner is the first set bit of req_i searching from index last_q+1 upward, modulo 4.
- Winner actions in that cycle:
  - gnt_o has only the winner's bit set, combinationally.
  - At the clock edge: data_o <= the winner's data word, sel_o <= winner index, last_q <= winner index, valid_o <= 1, state <= HOLD.
- Emptying: if arb_en and req_i==0, then at the clock edge valid_o <= 0 and state <= IDLE. last_q is unchanged.
- HOLD with ready_i==0:
  - data_o, sel_o and valid_o are stable.
  - gnt_o=0 regardless of req_i.
  - Requesters keep waiting.
- Throughput and latency:
  - Back-to-back: one word per cycle while ready_i stays high and requests are present. Drain and refill happen in the same edge with no bubble.
  - Latency from req_i to valid_o is 1 cycle when IDLE.
- Fairness: a requester that has just won has the lowest priority next time. No requester waits more than 3 other grants.
- A requester deasserting req_i before its grant is legal. It is simply not considered.
- gnt_o never has more than one bit set. gnt_o is never set while arb_en==0.
- Invariant: valid_o==(state==HOLD).
- ready_i while valid_o==0 is ignored.

Decomposition:
- Shared package arb_pkg:
  - Typedef arb_state_e {IDLE, HOLD}.
  - Constants NUM_REQ=4, SEL_W=2.
  - Typedef sel_t as logic [SEL_W-1:0].
- One sub-module, rr_pick:
  - Combinational.
  - Inputs: req (4 bits) and last (2 bits).
  - Outputs: any, idx (2 bits), onehot (4 bits).
  - It implements the rotated priority search so it can be tested on its own.
- The top level holds the FSM, last_q, the output register and the data mux.

Test Plan:
1. After rst_i pulse, data0_i..data3_i=1,2,3,4, req_i=4'b1111, ready_i=1 held for 4 cycles.
   -> Grants in order 0,1,2,3, one per cycle. data_o sequence 1,2,3,4 with sel_o 00,01,10,11, valid_o continuously 1.
2. With req_i=4'b0100 only, from IDLE.
   -> gnt_o=4'b0100 in that cycle. Next cycle valid_o=1, data_o=3, sel_o=10.
3. Backpressure: the word from requester 1 is held, ready_i=0 for 3 cycles while req_i=4'b1101.
   -> data_o, sel_o and valid_o are unchanged and gnt_o=0 for all 3 cycles. On ready_i=1 the winner is requester 2 (searching 2,3,0).
4. Only requester 0 requests repeatedly, ready_i=1.
   -> It wins every cycle, since no competitor exists.
   -> Then req_i goes 4'b0001 -> 4'b0000 and valid_o drops to 0 one cycle after the last acceptance. The state is IDLE.
5. Assert rst_i asynchronously mid-cycle while valid_o=1 and data_o=4.
   -> valid_o=0, data_o=0, sel_o=00 immediately, without a clock edge. After release with req_i=4'b1001, requester 0 wins first (last_q=3).
6. Compare rr_pick against a reference model: exhaustive 16 req values x 4 last values.
   -> onehot is one-hot exactly when any=1, and idx matches the first set bit after last.
